tlb_miss_arbiter: RTL and testbench



---
 rtl/tlb_miss_arbiter.sv | 254 +++++++++++++++++++++++++
 tb/tb_tlb_miss_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_miss_arbiter.sv
// Round-robin arbiter for ITLB/DTLB misses: shared-TLB lookup, PTW walk on miss,
// one-cycle fill strobe back to the requester, with sfence.vma kill handling.
module tlb_miss_arbiter #(
    parameter int unsigned VpnWidth  = 27,
    parameter int unsigned AsidWidth = 16,
    parameter int unsigned PteWidth  = 64,
    parameter int unsigned LvlWidth  = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,

    input  logic                 itlb_miss_valid_i,
    output logic                 itlb_miss_ready_o,
    input  logic [VpnWidth-1:0]  itlb_miss_vpn_i,
    input  logic [AsidWidth-1:0] itlb_miss_asid_i,

    input  logic                 dtlb_miss_valid_i,
    output logic                 dtlb_miss_ready_o,
    input  logic [VpnWidth-1:0]  dtlb_miss_vpn_i,
    input  logic [AsidWidth-1:0] dtlb_miss_asid_i,

    output logic                 stlb_req_valid_o,
    input  logic                 stlb_req_ready_i,
    output logic [VpnWidth-1:0]  stlb_req_vpn_o,
    output logic [AsidWidth-1:0] stlb_req_asid_o,
    input  logic                 stlb_rsp_valid_i,
    input  logic                 stlb_rsp_hit_i,
    input  logic [PteWidth-1:0]  stlb_rsp_pte_i,
    input  logic [LvlWidth-1:0]  stlb_rsp_lvl_i,

    output logic                 ptw_req_valid_o,
    input  logic                 ptw_req_ready_i,
    output logic [VpnWidth-1:0]  ptw_req_vpn_o,
    output logic [AsidWidth-1:0] ptw_req_asid_o,
    output logic                 ptw_req_is_instr_o,
    input  logic                 ptw_rsp_valid_i,
    input  logic                 ptw_rsp_fault_i,
    input  logic [PteWidth-1:0]  ptw_rsp_pte_i,
    input  logic [LvlWidth-1:0]  ptw_rsp_lvl_i,

    output logic                 itlb_fill_valid_o,
    output logic                 dtlb_fill_valid_o,
    output logic [VpnWidth-1:0]  fill_vpn_o,
    output logic [AsidWidth-1:0] fill_asid_o,
    output logic [PteWidth-1:0]  fill_pte_o,
    output logic [LvlWidth-1:0]  fill_lvl_o,
    output logic                 fill_fault_o,
    output logic                 fill_from_ptw_o,
    output logic                 busy_o
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        WAIT_STLB = 3'd2,
        PTW_REQ   = 3'd3,
        WAIT_PTW  = 3'd4,
        FILL      = 3'd5
    } state_e;

    state_e                 state_q;
    state_e                 state_d;
    logic                   rr_q;
    logic                   kill_q;
    logic                   kill_next;
    logic                   kill_d;
    logic                   grant_itlb;
    logic                   grant_dtlb;
    logic                   accept;
    logic                   load_fill;
    logic                   fill_src_ptw;
    logic                   fill_active;

    logic [VpnWidth-1:0]    vpn_q;
    logic [AsidWidth-1:0]   asid_q;
    logic                   is_instr_q;
    logic [VpnWidth-1:0]    fill_vpn_q;
    logic [AsidWidth-1:0]   fill_asid_q;
    logic [PteWidth-1:0]    fill_pte_q;
    logic [LvlWidth-1:0]    fill_lvl_q;
    logic                   fill_fault_q;
    logic                   from_ptw_q;

    // Grant selection; rr_q=0 favours the DTLB when both miss together
    always_comb begin
        grant_itlb = 1'b0;
        grant_dtlb = 1'b0;
        if ((state_q == IDLE) && !flush_i) begin
            if (itlb_miss_valid_i && dtlb_miss_valid_i) begin
                grant_itlb = rr_q;
                grant_dtlb = ~rr_q;
            end else if (itlb_miss_valid_i) begin
                grant_itlb = 1'b1;
            end else if (dtlb_miss_valid_i) begin
                grant_dtlb = 1'b1;
            end else begin
                grant_itlb = 1'b0;
                grant_dtlb = 1'b0;
            end
        end else begin
            grant_itlb = 1'b0;
            grant_dtlb = 1'b0;
        end
    end

    // Next-state logic; once a request is accepted downstream a flush only marks
    // the translation as killed so the outstanding response is still consumed
    always_comb begin
        state_d      = state_q;
        kill_next    = kill_q;
        accept       = 1'b0;
        load_fill    = 1'b0;
        fill_src_ptw = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_itlb || grant_dtlb) begin
                    accept  = 1'b1;
                    state_d = LOOKUP;
                end else begin
                    state_d = IDLE;
                end
            end
            LOOKUP: begin
                if (stlb_req_ready_i) begin
                    state_d   = WAIT_STLB;
                    kill_next = kill_q | flush_i;
                end else if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = LOOKUP;
                end
            end
            WAIT_STLB: begin
                kill_next = kill_q | flush_i;
                if (stlb_rsp_valid_i) begin
                    if (stlb_rsp_hit_i) begin
                        state_d   = FILL;
                        load_fill = 1'b1;
                    end else if (kill_q || flush_i) begin
                        // Killed miss: no point starting a walk nobody will use
                        state_d = IDLE;
                    end else begin
                        state_d = PTW_REQ;
                    end
                end else begin
                    state_d = WAIT_STLB;
                end
            end
            PTW_REQ: begin
                if (ptw_req_ready_i) begin
                    state_d   = WAIT_PTW;
                    kill_next = kill_q | flush_i;
                end else if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = PTW_REQ;
                end
            end
            WAIT_PTW: begin
                kill_next = kill_q | flush_i;
                if (ptw_rsp_valid_i) begin
                    state_d      = FILL;
                    load_fill    = 1'b1;
                    fill_src_ptw = 1'b1;
                end else begin
                    state_d = WAIT_PTW;
                end
            end
            FILL: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                kill_next = 1'b0;
            end
        endcase
        kill_d = (state_d == IDLE) ? 1'b0 : kill_next;
    end

    // Control state registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
            if (accept) begin
                rr_q <= ~rr_q;
            end
        end
    end

    // Latched request payload, held for the whole translation
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vpn_q      <= '0;
            asid_q     <= '0;
            is_instr_q <= 1'b0;
        end else if (accept) begin
            vpn_q      <= grant_itlb ? itlb_miss_vpn_i  : dtlb_miss_vpn_i;
            asid_q     <= grant_itlb ? itlb_miss_asid_i : dtlb_miss_asid_i;
            is_instr_q <= grant_itlb;
        end
    end

    // Fill payload registers; they keep the last fill between translations
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fill_vpn_q   <= '0;
            fill_asid_q  <= '0;
            fill_pte_q   <= '0;
            fill_lvl_q   <= '0;
            fill_fault_q <= 1'b0;
            from_ptw_q   <= 1'b0;
        end else if (load_fill) begin
            fill_vpn_q   <= vpn_q;
            fill_asid_q  <= asid_q;
            fill_pte_q   <= fill_src_ptw ? ptw_rsp_pte_i : stlb_rsp_pte_i;
            fill_lvl_q   <= fill_src_ptw ? ptw_rsp_lvl_i : stlb_rsp_lvl_i;
            fill_fault_q <= fill_src_ptw & ptw_rsp_fault_i;
            from_ptw_q   <= fill_src_ptw;
        end
    end

    // A flush landing in the FILL cycle itself also suppresses the strobe
    assign fill_active        = (state_q == FILL) && !kill_q && !flush_i;

    assign itlb_miss_ready_o  = grant_itlb;
    assign dtlb_miss_ready_o  = grant_dtlb;

    assign stlb_req_valid_o   = (state_q == LOOKUP);
    assign stlb_req_vpn_o     = vpn_q;
    assign stlb_req_asid_o    = asid_q;

    assign ptw_req_valid_o    = (state_q == PTW_REQ);
    assign ptw_req_vpn_o      = vpn_q;
    assign ptw_req_asid_o     = asid_q;
    assign ptw_req_is_instr_o = is_instr_q;

    assign itlb_fill_valid_o  = fill_active && is_instr_q;
    assign dtlb_fill_valid_o  = fill_active && !is_instr_q;
    assign fill_vpn_o         = fill_vpn_q;
    assign fill_asid_o        = fill_asid_q;
    assign fill_pte_o         = fill_pte_q;
    assign fill_lvl_o         = fill_lvl_q;
    assign fill_fault_o       = fill_fault_q;
    assign fill_from_ptw_o    = fill_active && from_ptw_q;

    assign busy_o             = (state_q != IDLE);

endmodule

// File: tb/tb_tlb_miss_arbiter.sv
// Directed bench for tlb_miss_arbiter: a vector table of complete translations
// plus hand-written arbitration, flush and reset sequences.
module tb_tlb_miss_arbiter;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        itlb_miss_valid_i, itlb_miss_ready_o;
    logic [26:0] itlb_miss_vpn_i;
    logic [15:0] itlb_miss_asid_i;
    logic        dtlb_miss_valid_i, dtlb_miss_ready_o;
    logic [26:0] dtlb_miss_vpn_i;
    logic [15:0] dtlb_miss_asid_i;
    logic        stlb_req_valid_o, stlb_req_ready_i;
    logic [26:0] stlb_req_vpn_o;
    logic [15:0] stlb_req_asid_o;
    logic        stlb_rsp_valid_i, stlb_rsp_hit_i;
    logic [63:0] stlb_rsp_pte_i;
    logic [1:0]  stlb_rsp_lvl_i;
    logic        ptw_req_valid_o, ptw_req_ready_i;
    logic [26:0] ptw_req_vpn_o;
    logic [15:0] ptw_req_asid_o;
    logic        ptw_req_is_instr_o;
    logic        ptw_rsp_valid_i, ptw_rsp_fault_i;
    logic [63:0] ptw_rsp_pte_i;
    logic [1:0]  ptw_rsp_lvl_i;
    logic        itlb_fill_valid_o, dtlb_fill_valid_o;
    logic [26:0] fill_vpn_o;
    logic [15:0] fill_asid_o;
    logic [63:0] fill_pte_o;
    logic [1:0]  fill_lvl_o;
    logic        fill_fault_o, fill_from_ptw_o, busy_o;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    tlb_miss_arbiter dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
        .itlb_miss_valid_i(itlb_miss_valid_i), .itlb_miss_ready_o(itlb_miss_ready_o),
        .itlb_miss_vpn_i(itlb_miss_vpn_i), .itlb_miss_asid_i(itlb_miss_asid_i),
        .dtlb_miss_valid_i(dtlb_miss_valid_i), .dtlb_miss_ready_o(dtlb_miss_ready_o),
        .dtlb_miss_vpn_i(dtlb_miss_vpn_i), .dtlb_miss_asid_i(dtlb_miss_asid_i),
        .stlb_req_valid_o(stlb_req_valid_o), .stlb_req_ready_i(stlb_req_ready_i),
        .stlb_req_vpn_o(stlb_req_vpn_o), .stlb_req_asid_o(stlb_req_asid_o),
        .stlb_rsp_valid_i(stlb_rsp_valid_i), .stlb_rsp_hit_i(stlb_rsp_hit_i),
        .stlb_rsp_pte_i(stlb_rsp_pte_i), .stlb_rsp_lvl_i(stlb_rsp_lvl_i),
        .ptw_req_valid_o(ptw_req_valid_o), .ptw_req_ready_i(ptw_req_ready_i),
        .ptw_req_vpn_o(ptw_req_vpn_o), .ptw_req_asid_o(ptw_req_asid_o),
        .ptw_req_is_instr_o(ptw_req_is_instr_o),
        .ptw_rsp_valid_i(ptw_rsp_valid_i), .ptw_rsp_fault_i(ptw_rsp_fault_i),
        .ptw_rsp_pte_i(ptw_rsp_pte_i), .ptw_rsp_lvl_i(ptw_rsp_lvl_i),
        .itlb_fill_valid_o(itlb_fill_valid_o), .dtlb_fill_valid_o(dtlb_fill_valid_o),
        .fill_vpn_o(fill_vpn_o), .fill_asid_o(fill_asid_o), .fill_pte_o(fill_pte_o),
        .fill_lvl_o(fill_lvl_o), .fill_fault_o(fill_fault_o),
        .fill_from_ptw_o(fill_from_ptw_o), .busy_o(busy_o)
    );

    typedef struct {
        logic        i_valid;
        logic        d_valid;
        logic [26:0] i_vpn;
        logic [26:0] d_vpn;
        logic [15:0] asid;
        logic        hit;
        logic [63:0] pte;
        logic [1:0]  lvl;
        logic        fault;
        int          ptw_delay;
        logic        exp_instr;
        logic [26:0] exp_vpn;
        logic        exp_fault;
        logic        exp_from_ptw;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input vec_t v);
        itlb_miss_valid_i = v.i_valid;
        itlb_miss_vpn_i   = v.i_vpn;
        itlb_miss_asid_i  = v.asid;
        dtlb_miss_valid_i = v.d_valid;
        dtlb_miss_vpn_i   = v.d_vpn;
        dtlb_miss_asid_i  = v.asid;
        #1;
        chk("t_ready_itlb", itlb_miss_ready_o, v.exp_instr);
        chk("t_ready_dtlb", dtlb_miss_ready_o, !v.exp_instr);
        tick;
        itlb_miss_valid_i = 1'b0;
        dtlb_miss_valid_i = 1'b0;
        chk("t_busy_lookup", busy_o, 1'b1);
        chk("t_stlb_valid", stlb_req_valid_o, 1'b1);
        chk("t_stlb_vpn", stlb_req_vpn_o, v.exp_vpn);
        chk("t_stlb_asid", stlb_req_asid_o, v.asid);
        stlb_req_ready_i = 1'b1;
        tick;
        stlb_req_ready_i = 1'b0;
        stlb_rsp_valid_i = 1'b1;
        stlb_rsp_hit_i   = v.hit;
        stlb_rsp_pte_i   = v.hit ? v.pte : ~v.pte;
        stlb_rsp_lvl_i   = v.lvl;
        tick;
        stlb_rsp_valid_i = 1'b0;
        stlb_rsp_hit_i   = 1'b0;
        if (!v.hit) begin
            chk("t_ptw_valid", ptw_req_valid_o, 1'b1);
            chk("t_ptw_is_instr", ptw_req_is_instr_o, v.exp_instr);
            chk("t_ptw_vpn", ptw_req_vpn_o, v.exp_vpn);
            for (int k = 0; k < v.ptw_delay; k++) begin
                tick;
                chk("t_ptw_hold", {ptw_req_valid_o, ptw_req_is_instr_o}, {1'b1, v.exp_instr});
            end
            ptw_req_ready_i = 1'b1;
            tick;
            ptw_req_ready_i = 1'b0;
            ptw_rsp_valid_i = 1'b1;
            ptw_rsp_fault_i = v.fault;
            ptw_rsp_pte_i   = v.pte;
            ptw_rsp_lvl_i   = v.lvl;
            tick;
            ptw_rsp_valid_i = 1'b0;
            ptw_rsp_fault_i = 1'b0;
        end
        chk("t_fill_itlb", itlb_fill_valid_o, v.exp_instr);
        chk("t_fill_dtlb", dtlb_fill_valid_o, !v.exp_instr);
        chk("t_fill_pte", fill_pte_o, v.pte);
        chk("t_fill_lvl", fill_lvl_o, v.lvl);
        chk("t_fill_fault", fill_fault_o, v.exp_fault);
        chk("t_fill_from_ptw", fill_from_ptw_o, v.exp_from_ptw);
        chk("t_fill_vpn", fill_vpn_o, v.exp_vpn);
        chk("t_fill_asid", fill_asid_o, v.asid);
        tick;
        chk("t_strobe_off", {itlb_fill_valid_o, dtlb_fill_valid_o, fill_from_ptw_o}, 3'b000);
        chk("t_busy_idle", busy_o, 1'b0);
        chk("t_pte_held", fill_pte_o, v.pte);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{i_valid:1'b0, d_valid:1'b1, i_vpn:27'h0, d_vpn:27'h1234, asid:16'h5,
                    hit:1'b1, pte:64'hCF, lvl:2'd0, fault:1'b0, ptw_delay:0,
                    exp_instr:1'b0, exp_vpn:27'h1234, exp_fault:1'b0, exp_from_ptw:1'b0};
        vecs[1] = '{i_valid:1'b1, d_valid:1'b1, i_vpn:27'h111, d_vpn:27'h222, asid:16'hA,
                    hit:1'b1, pte:64'hAB, lvl:2'd1, fault:1'b0, ptw_delay:0,
                    exp_instr:1'b1, exp_vpn:27'h111, exp_fault:1'b0, exp_from_ptw:1'b0};
        vecs[2] = '{i_valid:1'b1, d_valid:1'b0, i_vpn:27'h30000, d_vpn:27'h0, asid:16'h21,
                    hit:1'b0, pte:64'h10_0000_00CF, lvl:2'd2, fault:1'b0, ptw_delay:2,
                    exp_instr:1'b1, exp_vpn:27'h30000, exp_fault:1'b0, exp_from_ptw:1'b1};
        vecs[3] = '{i_valid:1'b0, d_valid:1'b1, i_vpn:27'h0, d_vpn:27'h45678, asid:16'h3,
                    hit:1'b0, pte:64'hDEAD, lvl:2'd0, fault:1'b1, ptw_delay:0,
                    exp_instr:1'b0, exp_vpn:27'h45678, exp_fault:1'b1, exp_from_ptw:1'b1};
        vecs[4] = '{i_valid:1'b1, d_valid:1'b1, i_vpn:27'h0, d_vpn:27'h7FFFFFF, asid:16'hFFFF,
                    hit:1'b1, pte:64'hFFFF_FFFF_FFFF_FFFF, lvl:2'd2, fault:1'b0, ptw_delay:0,
                    exp_instr:1'b0, exp_vpn:27'h7FFFFFF, exp_fault:1'b0, exp_from_ptw:1'b0};
        vecs[5] = '{i_valid:1'b1, d_valid:1'b1, i_vpn:27'h2AAAAAA, d_vpn:27'h1555555, asid:16'h77,
                    hit:1'b0, pte:64'h8000_0000_0000_0001, lvl:2'd1, fault:1'b0, ptw_delay:1,
                    exp_instr:1'b1, exp_vpn:27'h2AAAAAA, exp_fault:1'b0, exp_from_ptw:1'b1};

        rst_i = 1'b1; flush_i = 1'b0;
        itlb_miss_valid_i = 1'b0; itlb_miss_vpn_i = 27'h0; itlb_miss_asid_i = 16'h0;
        dtlb_miss_valid_i = 1'b0; dtlb_miss_vpn_i = 27'h0; dtlb_miss_asid_i = 16'h0;
        stlb_req_ready_i = 1'b0; stlb_rsp_valid_i = 1'b0; stlb_rsp_hit_i = 1'b0;
        stlb_rsp_pte_i = 64'h0; stlb_rsp_lvl_i = 2'd0;
        ptw_req_ready_i = 1'b0; ptw_rsp_valid_i = 1'b0; ptw_rsp_fault_i = 1'b0;
        ptw_rsp_pte_i = 64'h0; ptw_rsp_lvl_i = 2'd0;
        tick;
        tick;
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_req_valids", {stlb_req_valid_o, ptw_req_valid_o}, 2'b00);
        chk("rst_strobes", {itlb_fill_valid_o, dtlb_fill_valid_o, fill_from_ptw_o}, 3'b000);
        chk("rst_fill_pte", fill_pte_o, 64'h0);
        chk("rst_fill_vpn", fill_vpn_o, 27'h0);
        chk("rst_fill_misc", {fill_fault_o, fill_lvl_o}, 3'b000);
        rst_i = 1'b0;
        tick;

        // Both sources held valid: DTLB, ITLB, DTLB back to back
        itlb_miss_valid_i = 1'b1; itlb_miss_vpn_i = 27'h100; itlb_miss_asid_i = 16'h1;
        dtlb_miss_valid_i = 1'b1; dtlb_miss_vpn_i = 27'h200; dtlb_miss_asid_i = 16'h2;
        #1;
        for (int g = 0; g < 3; g++) begin
            logic exp_i;
            exp_i = (g == 1);
            chk("arb_ready_itlb", itlb_miss_ready_o, exp_i);
            chk("arb_ready_dtlb", dtlb_miss_ready_o, !exp_i);
            tick;
            chk("arb_vpn", stlb_req_vpn_o, exp_i ? 27'h100 : 27'h200);
            chk("arb_loser_ready", {itlb_miss_ready_o, dtlb_miss_ready_o}, 2'b00);
            stlb_req_ready_i = 1'b1;
            tick;
            stlb_req_ready_i = 1'b0;
            chk("arb_wait_ready", {itlb_miss_ready_o, dtlb_miss_ready_o}, 2'b00);
            stlb_rsp_valid_i = 1'b1; stlb_rsp_hit_i = 1'b1;
            stlb_rsp_pte_i = 64'h40; stlb_rsp_lvl_i = 2'd0;
            tick;
            stlb_rsp_valid_i = 1'b0; stlb_rsp_hit_i = 1'b0;
            chk("arb_fill", {itlb_fill_valid_o, dtlb_fill_valid_o}, {exp_i, !exp_i});
            chk("arb_fill_ready", {itlb_miss_ready_o, dtlb_miss_ready_o}, 2'b00);
            tick;
        end
        itlb_miss_valid_i = 1'b0;
        dtlb_miss_valid_i = 1'b0;
        tick;

        // Flush in IDLE blocks a simultaneous grant
        dtlb_miss_valid_i = 1'b1; dtlb_miss_vpn_i = 27'h333; flush_i = 1'b1;
        #1;
        chk("flush_idle_ready", dtlb_miss_ready_o, 1'b0);
        tick;
        flush_i = 1'b0;
        dtlb_miss_valid_i = 1'b0;
        chk("flush_idle_busy", busy_o, 1'b0);

        // Flush in LOOKUP withdraws the lookup request
        dtlb_miss_valid_i = 1'b1;
        #1;
        tick;
        dtlb_miss_valid_i = 1'b0;
        chk("flush_lookup_pre", stlb_req_valid_o, 1'b1);
        flush_i = 1'b1;
        tick;
        flush_i = 1'b0;
        chk("flush_lookup_valid", stlb_req_valid_o, 1'b0);
        chk("flush_lookup_busy", busy_o, 1'b0);
        tick;
        chk("flush_lookup_nofill", {itlb_fill_valid_o, dtlb_fill_valid_o}, 2'b00);

        // Flush in WAIT_PTW: response still consumed, fill suppressed
        itlb_miss_valid_i = 1'b1; itlb_miss_vpn_i = 27'h444; itlb_miss_asid_i = 16'h7;
        #1;
        tick;
        itlb_miss_valid_i = 1'b0;
        stlb_req_ready_i = 1'b1;
        tick;
        stlb_req_ready_i = 1'b0;
        stlb_rsp_valid_i = 1'b1; stlb_rsp_hit_i = 1'b0;
        tick;
        stlb_rsp_valid_i = 1'b0;
        chk("kill_ptw_req", ptw_req_valid_o, 1'b1);
        ptw_req_ready_i = 1'b1;
        tick;
        ptw_req_ready_i = 1'b0;
        flush_i = 1'b1;
        tick;
        flush_i = 1'b0;
        chk("kill_still_busy", busy_o, 1'b1);
        tick;
        chk("kill_still_waiting", busy_o, 1'b1);
        ptw_rsp_valid_i = 1'b1; ptw_rsp_pte_i = 64'h55; ptw_rsp_lvl_i = 2'd1;
        tick;
        ptw_rsp_valid_i = 1'b0;
        chk("kill_no_strobe", {itlb_fill_valid_o, dtlb_fill_valid_o, fill_from_ptw_o}, 3'b000);
        chk("kill_fill_busy", busy_o, 1'b1);
        tick;
        chk("kill_busy_falls", busy_o, 1'b0);

        // Async reset in WAIT_STLB, then a stale response in IDLE
        dtlb_miss_valid_i = 1'b1; dtlb_miss_vpn_i = 27'h555;
        #1;
        tick;
        dtlb_miss_valid_i = 1'b0;
        stlb_req_ready_i = 1'b1;
        tick;
        stlb_req_ready_i = 1'b0;
        chk("rst_mid_pre_busy", busy_o, 1'b1);
        rst_i = 1'b1;
        #1;
        chk("rst_mid_busy", busy_o, 1'b0);
        chk("rst_mid_valids", {stlb_req_valid_o, ptw_req_valid_o}, 2'b00);
        chk("rst_mid_pte", fill_pte_o, 64'h0);
        tick;
        rst_i = 1'b0;
        tick;
        stlb_rsp_valid_i = 1'b1; stlb_rsp_hit_i = 1'b1; stlb_rsp_pte_i = 64'h99;
        tick;
        stlb_rsp_valid_i = 1'b0; stlb_rsp_hit_i = 1'b0;
        chk("stale_busy", busy_o, 1'b0);
        chk("stale_strobe", {itlb_fill_valid_o, dtlb_fill_valid_o}, 2'b00);
        tick;
        chk("stale_pte", fill_pte_o, 64'h0);

        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i]);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
